control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
- Parametrised successor to the single-cycle control decode: decodes a MIPS instruction word, then carries the decoded control bundle through a configurable-depth pipeline (ID/EX onward).
- Per-stage destination and write info is exported for forwarding and hazard logic.
- Detects load-use hazards and inserts bubbles.
- Handles global stall, branch flush and a sticky halt.

Parameters:
STAGES, 3, number of control pipeline stages after decode (legal 2..5); stage 0 = ID/EX, stage STAGES-1 = MEM/WB.
LOAD_USE, 1, 1 enables load-use hazard detection; 0 forces hazard=0.

Ports:
CLK  input  1  rising-edge clock.
nRST  input  1  asynchronous active-low reset.
instr  input  32  instruction from fetch (cpu_types_pkg word_t).
instr_valid  input  1  instr is valid this cycle (ihit).
stall  input  1  global freeze (e.g. dcache miss): all stages hold.
flush  input  1  taken branch/jump: bubble into stage 0.
hazard  output  1  load-use stall request to fetch (hold PC and instr).
ctrl_valid  output  STAGES  per-stage valid.
ctrl_regwr  output  STAGES  per-stage register write enable.
ctrl_wsel  output  5*STAGES  per-stage destination register, stage i at bits [5i+4:5i].
ctrl_dren  output  STAGES  per-stage data read.
ctrl_dwen  output  STAGES  per-stage data write.
ex_aluctr  output  4  stage-0 ALU op (aluop_t).
ex_alusrc, ex_extop, ex_lui, ex_memtoreg, ex_beq, ex_bne, ex_jump, ex_jr, ex_jal  output  1 each  stage-0 controls.
ex_imm  output  16  stage-0 immediate.
ex_shamt  output  5  stage-0 shift amount.
halt  output  1  sticky halt; asserted once a halt instruction reaches stage STAGES-1.

Behaviour:
- Interface: one clock (CLK); reset (nRST) is asynchronous and active-low.
- Reset: every stage valid=0 and all fields 0; hazard=0; halt=0; halt_pending=0.
- A reset mid-operation discards all in-flight state immediately.
- Decode (combinational on instr):
  - RTYPE: regwr=1 except JR; wsel=rd; aluctr from funct; SLL/SRL use shamt.
  - I-type ALU: wsel=rt, alusrc=1. extop=1 for ADDI/ADDIU/SLTI/SLTIU; extop=0 for ANDI/ORI/XORI/LUI.
  - LW: dren=1, memtoreg=1, wsel=rt.
  - SW: dwen=1, regwr=0.
  - BEQ/BNE: aluctr=SUB, regwr=0.
  - J: jump=1.
  - JAL: jump=1, jal=1, wsel=31, regwr=1.
  - HALT (opcode 6'h3F): halt bit set, no writes.
  - Undefined opcode: decoded as bubble.
  - regwr is forced to 0 whenever wsel=0.
- Stage-0 load priority, highest first:
  1. stall: all stages hold; hazard output still computed but has no effect.
  2. flush: stage 0 <= bubble.
  3. hazard: stage 0 <= bubble.
  4. halt_pending or !instr_valid: stage 0 <= bubble.
  5. otherwise: stage 0 <= decoded instr.
- When not stalled, stage i <= stage i-1 for i>=1. A bubble is valid=0 with all write/mem/branch bits 0.
- Latency: instr accepted at edge t is in stage 0 after t; in stage k after t+k, absent stall.
- hazard is combinational and equals 1 when all of the following hold:
  - LOAD_USE=1 and instr_valid;
  - stage 0 valid with dren=1 and wsel!=0;
  - wsel==rs, or (wsel==rt and the instruction reads rt: RTYPE, BEQ, BNE, SW).
- hazard produces exactly one bubble, after which the load has moved to stage 1 and hazard deasserts.
- halt_pending sets when a halt instruction is loaded into stage 0; all later entries are bubbles until reset.
- A flush on the same edge as the halt instruction prevents the halt from loading, and halt_pending stays 0.
- halt sets when stage STAGES-1 is valid with its halt bit set; it is sticky until nRST.
- The full bundle carries rs/rt internally; only the listed fields are exported.

Test Plan:
- Reset, then ADDI $5,$0,7 with instr_valid=1 at t0 -> t0+1: ctrl_valid[0]=1, wsel[0]=5, regwr[0]=1, alusrc=1, extop=1; reaches stage 2 at t0+3 (STAGES=3).
- LW $8,0($4) then ADD $9,$8,$2 -> hazard=1 for one cycle; stage 0 holds a bubble; ADD enters the following cycle; with LOAD_USE=0, hazard stays 0.
- Issue ORI while stall=1 for 3 cycles -> all stage outputs frozen; ORI is in stage 0 on the first edge after stall drops; extop=0.
- BEQ in stage 0, flush=1 with a valid SUB at input -> stage 0 becomes a bubble; ctrl_regwr[0]=0, ctrl_valid[0]=0.
- HALT followed by valid ADDs -> the ADDs enter as bubbles; halt=1 after 3 cycles (STAGES=3) and stays 1; nRST low asynchronously clears halt and all valids.
- ADD $0,$1,$2 and JAL -> regwr=0 for the $0 destination; JAL gives wsel=31, regwr=1, jal=1, jump=1.

Source files
------------

// File: rtl/control_pipe.sv
// control_pipe: decodes a MIPS instruction word and carries its control bundle down a STAGES-deep pipe.
// Latency: an instr accepted at edge t is in stage 0 after t and in stage k after t+k (absent stall).
// Backpressure: stall freezes every stage; a load-use hit raises hazard and loads a bubble in its place.
//
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   instr/instr_valid  instruction word from fetch and its valid
//   stall, flush       global freeze; taken branch/jump bubble into stage 0
//   hazard             load-use stall request back to fetch (fetch holds PC and instr)
//   ctrl_*             per-stage valid/regwr/wsel/dren/dwen, stage i at bit i (wsel at [5i+4:5i])
//   ex_*               stage-0 (ID/EX) execute controls, immediate and shift amount
//   halt               sticky; raised once a halt instruction reaches stage STAGES-1
module control_pipe #(
    parameter int STAGES   = 3,    // legal 2..5; stage 0 = ID/EX, stage STAGES-1 = MEM/WB
    parameter int LOAD_USE = 1     // 0 disables load-use detection entirely
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  hazard,
    output logic [STAGES-1:0]     ctrl_valid,
    output logic [STAGES-1:0]     ctrl_regwr,
    output logic [5*STAGES-1:0]   ctrl_wsel,
    output logic [STAGES-1:0]     ctrl_dren,
    output logic [STAGES-1:0]     ctrl_dwen,
    output logic [3:0]            ex_aluctr,
    output logic                  ex_alusrc,
    output logic                  ex_extop,
    output logic                  ex_lui,
    output logic                  ex_memtoreg,
    output logic                  ex_beq,
    output logic                  ex_bne,
    output logic                  ex_jump,
    output logic                  ex_jr,
    output logic                  ex_jal,
    output logic [15:0]           ex_imm,
    output logic [4:0]            ex_shamt,
    output logic                  halt
);

    // opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E,
                           OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B,
                           OP_HALT  = 6'h3F;
    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08,
                           FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22,
                           FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                           FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
                           FN_SLTU = 6'h2B;
    // aluop_t encoding
    localparam logic [3:0] ALU_SLL = 4'h0, ALU_SRL = 4'h1, ALU_ADD = 4'h2, ALU_SUB  = 4'h3,
                           ALU_AND = 4'h4, ALU_OR  = 4'h5, ALU_XOR = 4'h6, ALU_NOR  = 4'h7,
                           ALU_SLT = 4'hA, ALU_SLTU = 4'hB;

    typedef struct packed {
        logic        valid;
        logic        regwr;
        logic [4:0]  wsel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        dren;
        logic        dwen;
        logic [3:0]  aluctr;
        logic        alusrc;
        logic        extop;
        logic        lui;
        logic        memtoreg;
        logic        beq;
        logic        bne;
        logic        jump;
        logic        jr;
        logic        jal;
        logic        hlt;
        logic [15:0] imm;
        logic [4:0]  shamt;
    } ctrl_t;

    ctrl_t       pipe [STAGES];
    ctrl_t       dec;
    logic        halt_pending;
    logic        halt_q;
    logic        reads_rt;
    logic        load;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // ---------------- decode ----------------
    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.valid = 1'b1;
                dec.wsel  = instr[15:11];
                dec.regwr = 1'b1;
                case (funct)
                    FN_SLL:          dec.aluctr = ALU_SLL;
                    FN_SRL:          dec.aluctr = ALU_SRL;
                    FN_ADD, FN_ADDU: dec.aluctr = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.aluctr = ALU_SUB;
                    FN_AND:          dec.aluctr = ALU_AND;
                    FN_OR:           dec.aluctr = ALU_OR;
                    FN_XOR:          dec.aluctr = ALU_XOR;
                    FN_NOR:          dec.aluctr = ALU_NOR;
                    FN_SLT:          dec.aluctr = ALU_SLT;
                    FN_SLTU:         dec.aluctr = ALU_SLTU;
                    FN_JR: begin
                        dec.jr    = 1'b1;
                        dec.regwr = 1'b0;
                    end
                    default:         dec.valid = 1'b0;   // unknown funct travels as a bubble
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.valid  = 1'b1;
                dec.wsel   = instr[20:16];
                dec.regwr  = 1'b1;
                dec.alusrc = 1'b1;
                // only the arithmetic/compare immediates sign-extend
                dec.extop  = (opcode == OP_ADDI) || (opcode == OP_ADDIU) ||
                             (opcode == OP_SLTI) || (opcode == OP_SLTIU);
                dec.lui    = (opcode == OP_LUI);
                case (opcode)
                    OP_SLTI:  dec.aluctr = ALU_SLT;
                    OP_SLTIU: dec.aluctr = ALU_SLTU;
                    OP_ANDI:  dec.aluctr = ALU_AND;
                    OP_ORI,
                    OP_LUI:   dec.aluctr = ALU_OR;
                    OP_XORI:  dec.aluctr = ALU_XOR;
                    default:  dec.aluctr = ALU_ADD;
                endcase
            end
            OP_LW: begin
                dec.valid    = 1'b1;
                dec.wsel     = instr[20:16];
                dec.regwr    = 1'b1;
                dec.dren     = 1'b1;
                dec.memtoreg = 1'b1;
                dec.alusrc   = 1'b1;
                dec.extop    = 1'b1;
                dec.aluctr   = ALU_ADD;
            end
            OP_SW: begin
                dec.valid  = 1'b1;
                dec.dwen   = 1'b1;
                dec.alusrc = 1'b1;
                dec.extop  = 1'b1;
                dec.aluctr = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                dec.valid  = 1'b1;
                dec.beq    = (opcode == OP_BEQ);
                dec.bne    = (opcode == OP_BNE);
                dec.aluctr = ALU_SUB;
            end
            OP_J: begin
                dec.valid = 1'b1;
                dec.jump  = 1'b1;
            end
            OP_JAL: begin
                dec.valid = 1'b1;
                dec.jump  = 1'b1;
                dec.jal   = 1'b1;
                dec.wsel  = 5'd31;
                dec.regwr = 1'b1;
            end
            OP_HALT: begin
                dec.valid = 1'b1;
                dec.hlt   = 1'b1;
            end
            default: ;
        endcase

        if (dec.valid) begin
            dec.rs    = instr[25:21];
            dec.rt    = instr[20:16];
            dec.imm   = instr[15:0];
            dec.shamt = instr[10:6];
            // $0 is never written
            if (dec.wsel == 5'd0) dec.regwr = 1'b0;
        end else begin
            dec = '0;
        end
    end

    // ---------------- load-use hazard ----------------
    assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                      (opcode == OP_BNE)   || (opcode == OP_SW);

    assign hazard = (LOAD_USE != 0) && instr_valid &&
                    pipe[0].valid && pipe[0].dren && (pipe[0].wsel != 5'd0) &&
                    ((pipe[0].wsel == instr[25:21]) ||
                     (reads_rt && (pipe[0].wsel == instr[20:16])));

    // flush, hazard, pending halt and idle fetch all resolve to a bubble in stage 0
    assign load = instr_valid && !flush && !hazard && !halt_pending;

    // ---------------- pipeline ----------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
            halt_pending <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            if (pipe[STAGES-1].valid && pipe[STAGES-1].hlt) halt_q <= 1'b1;
            if (!stall) begin
                pipe[0] <= load ? dec : '0;
                for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
                if (load && dec.hlt) halt_pending <= 1'b1;
            end
        end
    end

    // halt is visible in the same cycle the instruction occupies the last stage, then held
    assign halt = halt_q || (pipe[STAGES-1].valid && pipe[STAGES-1].hlt);

    // ---------------- exports ----------------
    always_comb begin
        ctrl_valid = '0;
        ctrl_regwr = '0;
        ctrl_wsel  = '0;
        ctrl_dren  = '0;
        ctrl_dwen  = '0;
        for (int i = 0; i < STAGES; i++) begin
            ctrl_valid[i]       = pipe[i].valid;
            ctrl_regwr[i]       = pipe[i].regwr;
            ctrl_wsel[5*i +: 5] = pipe[i].wsel;
            ctrl_dren[i]        = pipe[i].dren;
            ctrl_dwen[i]        = pipe[i].dwen;
        end
    end

    assign ex_aluctr   = pipe[0].aluctr;
    assign ex_alusrc   = pipe[0].alusrc;
    assign ex_extop    = pipe[0].extop;
    assign ex_lui      = pipe[0].lui;
    assign ex_memtoreg = pipe[0].memtoreg;
    assign ex_beq      = pipe[0].beq;
    assign ex_bne      = pipe[0].bne;
    assign ex_jump     = pipe[0].jump;
    assign ex_jr       = pipe[0].jr;
    assign ex_jal      = pipe[0].jal;
    assign ex_imm      = pipe[0].imm;
    assign ex_shamt    = pipe[0].shamt;

endmodule

// File: tb/tb_control_pipe.sv
module tb_control_pipe;
    localparam int S = 3;
    localparam logic [3:0] A_SLL = 4'h0, A_SRL = 4'h1, A_ADD = 4'h2, A_SUB = 4'h3,
                           A_AND = 4'h4, A_OR  = 4'h5, A_XOR = 4'h6, A_NOR = 4'h7,
                           A_SLT = 4'hA, A_SLTU = 4'hB;

    typedef enum int {
        M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
        M_SLL, M_SRL, M_JR,
        M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
        M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL, M_HALT, M_UNDEF
    } mn_t;

    typedef struct packed {
        logic        valid, regwr, dren, dwen;
        logic [4:0]  wsel;
        logic [3:0]  alu;
        logic        alusrc, extop, lui, m2r, beq, bne, jump, jr, jal, halt;
        logic [15:0] imm;
        logic [4:0]  sh;
    } bun_t;

    typedef struct packed {
        logic [S-1:0]   v, rw, dr, dw;
        logic [5*S-1:0] ws;
        logic [3:0]     alu;
        logic           alusrc, extop, lui, m2r, beq, bne, jump, jr, jal;
        logic [15:0]    imm;
        logic [4:0]     sh;
        logic           haz, hlt;
    } obs_t;

    typedef struct packed { obs_t a; obs_t b; } pair_t;

    // ---------------- DUT wiring ----------------
    logic        CLK = 1'b0, nRST = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0, stall = 1'b0, flush = 1'b0;

    logic           hz_a, asrc_a, ext_a, lui_a, m2r_a, beq_a, bne_a, jmp_a, jr_a, jal_a, hlt_a;
    logic [S-1:0]   cv_a, cr_a, cd_a, cdw_a;
    logic [5*S-1:0] cw_a;
    logic [3:0]     alu_a;
    logic [15:0]    imm_a;
    logic [4:0]     sh_a;
    logic           hz_b, asrc_b, ext_b, lui_b, m2r_b, beq_b, bne_b, jmp_b, jr_b, jal_b, hlt_b;
    logic [S-1:0]   cv_b, cr_b, cd_b, cdw_b;
    logic [5*S-1:0] cw_b;
    logic [3:0]     alu_b;
    logic [15:0]    imm_b;
    logic [4:0]     sh_b;
    obs_t           got_a, got_b;

    control_pipe #(.STAGES(S), .LOAD_USE(1)) dut (
        .CLK(CLK), .nRST(nRST), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .hazard(hz_a),
        .ctrl_valid(cv_a), .ctrl_regwr(cr_a), .ctrl_wsel(cw_a), .ctrl_dren(cd_a), .ctrl_dwen(cdw_a),
        .ex_aluctr(alu_a), .ex_alusrc(asrc_a), .ex_extop(ext_a), .ex_lui(lui_a),
        .ex_memtoreg(m2r_a), .ex_beq(beq_a), .ex_bne(bne_a), .ex_jump(jmp_a), .ex_jr(jr_a),
        .ex_jal(jal_a), .ex_imm(imm_a), .ex_shamt(sh_a), .halt(hlt_a)
    );

    control_pipe #(.STAGES(S), .LOAD_USE(0)) dut_nl (
        .CLK(CLK), .nRST(nRST), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .hazard(hz_b),
        .ctrl_valid(cv_b), .ctrl_regwr(cr_b), .ctrl_wsel(cw_b), .ctrl_dren(cd_b), .ctrl_dwen(cdw_b),
        .ex_aluctr(alu_b), .ex_alusrc(asrc_b), .ex_extop(ext_b), .ex_lui(lui_b),
        .ex_memtoreg(m2r_b), .ex_beq(beq_b), .ex_bne(bne_b), .ex_jump(jmp_b), .ex_jr(jr_b),
        .ex_jal(jal_b), .ex_imm(imm_b), .ex_shamt(sh_b), .halt(hlt_b)
    );

    assign got_a = {cv_a, cr_a, cd_a, cdw_a, cw_a, alu_a, asrc_a, ext_a, lui_a, m2r_a,
                    beq_a, bne_a, jmp_a, jr_a, jal_a, imm_a, sh_a, hz_a, hlt_a};
    assign got_b = {cv_b, cr_b, cd_b, cdw_b, cw_b, alu_b, asrc_b, ext_b, lui_b, m2r_b,
                    beq_b, bne_b, jmp_b, jr_b, jal_b, imm_b, sh_b, hz_b, hlt_b};

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    bun_t       st [2][S];      // [0]: load-use on, [1]: load-use off
    logic       hp [2];
    logic       hq [2];
    mn_t        cur_mn = M_SLL;
    pair_t      q [$];
    int         n_cmp = 0, n_bad = 0, mon_cyc = 0;
    logic       hold = 1'b0;
    logic [5:0] uops [6];

    function automatic logic is_r(mn_t mn);
        return mn <= M_JR;
    endfunction

    function automatic logic reads_rt(mn_t mn);
        return is_r(mn) || mn == M_BEQ || mn == M_BNE || mn == M_SW;
    endfunction

    function automatic logic [3:0] alu_of(mn_t mn);
        case (mn)
            M_ADD, M_ADDU, M_ADDI, M_ADDIU, M_LW, M_SW: return A_ADD;
            M_SUB, M_SUBU, M_BEQ, M_BNE:                return A_SUB;
            M_AND, M_ANDI:                              return A_AND;
            M_OR, M_ORI, M_LUI:                         return A_OR;
            M_XOR, M_XORI:                              return A_XOR;
            M_NOR:                                      return A_NOR;
            M_SLT, M_SLTI:                              return A_SLT;
            M_SLTU, M_SLTIU:                            return A_SLTU;
            M_SRL:                                      return A_SRL;
            default:                                    return A_SLL;
        endcase
    endfunction

    function automatic logic [31:0] encode(mn_t mn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                           logic [4:0] sh, logic [15:0] imm, logic [25:0] tgt,
                                           logic [5:0] uop);
        logic [5:0] op, fn;
        op = 6'h00;
        fn = 6'h00;
        case (mn)
            M_ADD:   fn = 6'h20;  M_ADDU: fn = 6'h21;  M_SUB:  fn = 6'h22;  M_SUBU: fn = 6'h23;
            M_AND:   fn = 6'h24;  M_OR:   fn = 6'h25;  M_XOR:  fn = 6'h26;  M_NOR:  fn = 6'h27;
            M_SLT:   fn = 6'h2A;  M_SLTU: fn = 6'h2B;  M_SLL:  fn = 6'h00;  M_SRL:  fn = 6'h02;
            M_JR:    fn = 6'h08;
            M_ADDI:  op = 6'h08;  M_ADDIU: op = 6'h09; M_SLTI: op = 6'h0A;  M_SLTIU: op = 6'h0B;
            M_ANDI:  op = 6'h0C;  M_ORI:   op = 6'h0D; M_XORI: op = 6'h0E;  M_LUI:   op = 6'h0F;
            M_LW:    op = 6'h23;  M_SW:    op = 6'h2B; M_BEQ:  op = 6'h04;  M_BNE:   op = 6'h05;
            M_J:     op = 6'h02;  M_JAL:   op = 6'h03; M_HALT: op = 6'h3F;
            default: op = uop;
        endcase
        if (is_r(mn)) return {6'h00, rs, rt, rd, sh, fn};
        if (mn == M_J || mn == M_JAL || mn == M_HALT || mn == M_UNDEF) return {op, tgt};
        return {op, rs, rt, imm};
    endfunction

    // what the instruction means, from its mnemonic
    function automatic bun_t ref_dec(mn_t mn, logic [31:0] w);
        bun_t b;
        b = '0;
        if (mn == M_UNDEF) return b;
        b.valid = 1'b1;
        b.alu   = alu_of(mn);
        b.imm   = w[15:0];
        b.sh    = w[10:6];
        if (is_r(mn)) begin
            b.wsel  = w[15:11];
            b.regwr = (mn != M_JR);
            b.jr    = (mn == M_JR);
        end else begin
            case (mn)
                M_ADDI, M_ADDIU, M_SLTI, M_SLTIU: begin
                    b.wsel = w[20:16]; b.regwr = 1'b1; b.alusrc = 1'b1; b.extop = 1'b1;
                end
                M_ANDI, M_ORI, M_XORI, M_LUI: begin
                    b.wsel = w[20:16]; b.regwr = 1'b1; b.alusrc = 1'b1; b.lui = (mn == M_LUI);
                end
                M_LW: begin
                    b.wsel = w[20:16]; b.regwr = 1'b1; b.dren = 1'b1; b.m2r = 1'b1;
                    b.alusrc = 1'b1; b.extop = 1'b1;
                end
                M_SW:   begin b.dwen = 1'b1; b.alusrc = 1'b1; b.extop = 1'b1; end
                M_BEQ:  b.beq = 1'b1;
                M_BNE:  b.bne = 1'b1;
                M_J:    b.jump = 1'b1;
                M_JAL:  begin b.jump = 1'b1; b.jal = 1'b1; b.wsel = 5'd31; b.regwr = 1'b1; end
                M_HALT: b.halt = 1'b1;
                default: ;
            endcase
        end
        if (b.wsel == 5'd0) b.regwr = 1'b0;
        return b;
    endfunction

    function automatic obs_t snap(int m);
        obs_t o;
        o = '0;
        for (int i = 0; i < S; i++) begin
            o.v[i]         = st[m][i].valid;
            o.rw[i]        = st[m][i].regwr;
            o.dr[i]        = st[m][i].dren;
            o.dw[i]        = st[m][i].dwen;
            o.ws[5*i +: 5] = st[m][i].wsel;
        end
        o.alu = st[m][0].alu;   o.alusrc = st[m][0].alusrc; o.extop = st[m][0].extop;
        o.lui = st[m][0].lui;   o.m2r = st[m][0].m2r;       o.beq = st[m][0].beq;
        o.bne = st[m][0].bne;   o.jump = st[m][0].jump;     o.jr = st[m][0].jr;
        o.jal = st[m][0].jal;   o.imm = st[m][0].imm;       o.sh = st[m][0].sh;
        return o;
    endfunction

    // expected outputs for the current cycle, then advance across the next edge
    task automatic model_step(input int m, input logic lu, output obs_t o);
        bun_t nb;
        logic hz;
        if (!nRST) begin
            for (int i = 0; i < S; i++) st[m][i] = '0;
            hp[m] = 1'b0;
            hq[m] = 1'b0;
        end
        hz = lu && instr_valid && st[m][0].valid && st[m][0].dren && (st[m][0].wsel != 5'd0) &&
             ((st[m][0].wsel == instr[25:21]) ||
              (reads_rt(cur_mn) && st[m][0].wsel == instr[20:16]));
        o     = snap(m);
        o.haz = hz;
        o.hlt = hq[m] || (st[m][S-1].valid && st[m][S-1].halt);
        if (!nRST) return;
        if (st[m][S-1].valid && st[m][S-1].halt) hq[m] = 1'b1;
        if (!stall) begin
            nb = (flush || hz || hp[m] || !instr_valid) ? bun_t'(0) : ref_dec(cur_mn, instr);
            for (int i = S-1; i >= 1; i--) st[m][i] = st[m][i-1];
            st[m][0] = nb;
            if (nb.halt) hp[m] = 1'b1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic rn, input mn_t mn, input logic [31:0] w,
                       input logic iv, input logic stl, input logic fl);
        pair_t p;
        @(posedge CLK);
        #1;
        nRST = rn; instr = w; cur_mn = mn; instr_valid = iv; stall = stl; flush = fl;
        model_step(0, 1'b1, p.a);
        model_step(1, 1'b0, p.b);
        q.push_back(p);
        hold = rn && (p.a.haz || stl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, M_SLL, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_instr(output mn_t mn, output logic [31:0] w);
        int k;
        k = $urandom_range(0, int'(M_UNDEF));
        if (k == int'(M_HALT)) k = int'(M_ADD);
        mn = mn_t'(k);
        w = encode(mn, 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                   5'($urandom), 16'($urandom), 26'($urandom), uops[$urandom_range(0, 5)]);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, mon_cyc, g, e);
        end
    endtask

    task automatic check(input string tag, input obs_t g, input obs_t e);
        chk({tag, ".pipe"}, 64'({g.v, g.rw, g.dr, g.dw, g.ws}), 64'({e.v, e.rw, e.dr, e.dw, e.ws}));
        chk({tag, ".ex"}, 64'({g.alu, g.alusrc, g.extop, g.lui, g.m2r, g.beq, g.bne, g.jump, g.jr,
                               g.jal, g.imm, g.sh}),
                          64'({e.alu, e.alusrc, e.extop, e.lui, e.m2r, e.beq, e.bne, e.jump, e.jr,
                               e.jal, e.imm, e.sh}));
        chk({tag, ".hazard"}, 64'(g.haz), 64'(e.haz));
        chk({tag, ".halt"}, 64'(g.hlt), 64'(e.hlt));
    endtask

    initial begin
        pair_t p;
        forever begin
            @(negedge CLK);
            mon_cyc++;
            if (q.size() > 0) begin
                p = q.pop_front();
                check("lu1", got_a, p.a);
                check("lu0", got_b, p.b);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        mn_t         mn;
        logic [31:0] w;
        logic        iv;
        uops[0] = 6'h01; uops[1] = 6'h06; uops[2] = 6'h07;
        uops[3] = 6'h10; uops[4] = 6'h20; uops[5] = 6'h30;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < S; i++) st[m][i] = '0;
            hp[m] = 1'b0;
            hq[m] = 1'b0;
        end

        // reset held
        cyc(1'b0, M_SLL, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, M_SLL, 32'h0, 1'b0, 1'b0, 1'b0);

        // ADDI $5,$0,7 walks to the last stage
        cyc(1'b1, M_ADDI, encode(M_ADDI, 5'd0, 5'd5, 5'd0, 5'd0, 16'd7, 26'd0, 6'd0), 1'b1, 1'b0, 1'b0);
        idle(4);

        // LW $8,0($4) then ADD $9,$8,$2, fetch re-presents ADD after the hazard
        cyc(1'b1, M_LW, encode(M_LW, 5'd4, 5'd8, 5'd0, 5'd0, 16'd0, 26'd0, 6'd0), 1'b1, 1'b0, 1'b0);
        w = encode(M_ADD, 5'd8, 5'd2, 5'd9, 5'd0, 16'd0, 26'd0, 6'd0);
        cyc(1'b1, M_ADD, w, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, M_ADD, w, 1'b1, 1'b0, 1'b0);
        idle(3);

        // ORI held under a 3-cycle stall with an ADDI already in flight
        cyc(1'b1, M_ADDI, encode(M_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFF0, 26'd0, 6'd0), 1'b1, 1'b0, 1'b0);
        w = encode(M_ORI, 5'd1, 5'd3, 5'd0, 5'd0, 16'h00F0, 26'd0, 6'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, M_ORI, w, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, M_ORI, w, 1'b1, 1'b0, 1'b0);
        idle(3);

        // BEQ in stage 0, flush kills the following SUB
        cyc(1'b1, M_BEQ, encode(M_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'd4, 26'd0, 6'd0), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, M_SUB, encode(M_SUB, 5'd1, 5'd2, 5'd6, 5'd0, 16'd0, 26'd0, 6'd0), 1'b1, 1'b0, 1'b1);
        idle(3);

        // $0 destination and JAL
        cyc(1'b1, M_ADD, encode(M_ADD, 5'd1, 5'd2, 5'd0, 5'd0, 16'd0, 26'd0, 6'd0), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, M_JAL, encode(M_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0123456, 6'd0), 1'b1, 1'b0, 1'b0);
        idle(3);

        // HALT, then ADDs become bubbles, halt sticks, async reset clears it
        cyc(1'b1, M_HALT, encode(M_HALT, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0, 6'd0), 1'b1, 1'b0, 1'b0);
        w = encode(M_ADD, 5'd1, 5'd2, 5'd7, 5'd0, 16'd0, 26'd0, 6'd0);
        for (int i = 0; i < 6; i++) cyc(1'b1, M_ADD, w, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, M_ADD, w, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, M_ADD, w, 1'b1, 1'b0, 1'b0);
        idle(3);

        // randomized traffic; fetch holds its instruction across hazard/stall
        mn = M_SLL; w = 32'h0; iv = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!hold) begin
                rand_instr(mn, w);
                iv = ($urandom_range(0, 7) != 0);
            end
            cyc(($urandom_range(0, 199) != 0), mn, w, iv,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
        end

        // halt again at the end, after random traffic
        cyc(1'b1, M_HALT, encode(M_HALT, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FF, 6'd0), 1'b1, 1'b0, 1'b0);
        idle(6);

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
